// File: rtl/fib_pkg.sv
// Shared definitions for the clocked Fibonacci-class term generator:
// FSM state encoding and well-known seed pairs.
package fib_pkg;

  typedef enum logic [1:0] {
    FIB_IDLE = 2'd0,
    FIB_CALC = 2'd1,
    FIB_DONE = 2'd2
  } fibState_t;

  // Seed pairs: x(0), x(1) for the Fibonacci and Lucas sequences.
  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/fib_datapath.sv
// Term recurrence datapath: holds a=x(i), b=x(i+1), sticky carry, index i and
// target n; advances one term per step strobe and flags i==n.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int Width  = 32,
  parameter int NWidth = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [NWidth-1:0] n,
  input  logic [Width-1:0]  seed0,
  input  logic [Width-1:0]  seed1,
  output logic [Width-1:0]  a,
  output logic              ovfAcc,
  output logic              atEnd,
  output logic              nextAtEnd
);

  logic [Width-1:0]  b;
  logic              bOvf;
  logic [NWidth-1:0] i;
  logic [NWidth-1:0] nQ;
  logic [Width:0]    sum;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign atEnd     = (i == nQ);
  assign nextAtEnd = ((i + NWidth'(1)) == nQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      bOvf   <= 1'b0;
      i      <= '0;
      nQ     <= '0;
      ovfAcc <= 1'b0;
    end else if (load) begin
      a      <= seed0;
      b      <= seed1;
      bOvf   <= 1'b0;
      i      <= '0;
      nQ     <= n;
      ovfAcc <= 1'b0;
    end else if (step) begin
      // NOTE: non-blocking assignments mean every right-hand side below is the
      // pre-edge value, so a, b, bOvf and ovfAcc all shift together.
      a      <= b;
      b      <= sum[Width-1:0];
      bOvf   <= bOvf | sum[Width];
      // The old bOvf describes x(i+1), which becomes the new a.
      ovfAcc <= ovfAcc | bOvf;
      i      <= i + NWidth'(1);
    end
  end

endmodule

// File: rtl/fibonacci_seq.sv
// Clocked Fibonacci-class term generator with four-phase req/fin handshake.
// Define FIB_STREAM_EN to add the term_vld/term stream of x(0)..x(n).
module fibonacci_seq
  import fib_pkg::*;
#(
  parameter int Width  = 32,
  parameter int NWidth = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [NWidth-1:0] n,
  input  logic [Width-1:0]  seed0,
  input  logic [Width-1:0]  seed1,
  output logic              fin,
  output logic              busy,
  output logic [Width-1:0]  result,
  output logic              ovf
`ifdef FIB_STREAM_EN
  ,
  output logic              term_vld,
  output logic [Width-1:0]  term
`endif
);

  fibState_t        state;
  logic             load;
  logic             step;
  logic             atEnd;
  logic             nextAtEnd;
  logic             ovfAcc;
  logic [Width-1:0] a;

  assign load = (state == FIB_IDLE) && req;
  assign step = (state == FIB_CALC) && req && !atEnd;

  fib_datapath #(
    .Width (Width),
    .NWidth(NWidth)
  ) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .n        (n),
    .seed0    (seed0),
    .seed1    (seed1),
    .a        (a),
    .ovfAcc   (ovfAcc),
    .atEnd    (atEnd),
    .nextAtEnd(nextAtEnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: result and ovf are reset along with control, so a fresh part
      // reads 0 rather than whatever the flops powered up with.
      state  <= FIB_IDLE;
      fin    <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        FIB_IDLE: begin
          if (req) begin
            state <= FIB_CALC;
            busy  <= (n != '0);
          end
        end
        FIB_CALC: begin
          if (!req) begin
            state <= FIB_IDLE;
            busy  <= 1'b0;
          end else if (atEnd) begin
            result <= a;
            ovf    <= ovfAcc;
            busy   <= 1'b0;
            state  <= FIB_DONE;
          end else begin
            // Busy covers the stepping cycles; it drops as i reaches n.
            busy <= !nextAtEnd;
          end
        end
        FIB_DONE: begin
          if (!req) begin
            fin   <= 1'b0;
            state <= FIB_IDLE;
          end else begin
            fin <= 1'b1;
          end
        end
        default: begin
          state <= FIB_IDLE;
          fin   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIB_STREAM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_vld <= 1'b0;
      term     <= '0;
    end else if ((state == FIB_CALC) && req) begin
      term_vld <= 1'b1;
      term     <= a;
    end else begin
      term_vld <= 1'b0;
      term     <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fibonacci_seq.sv
// Randomised bench for fibonacci_seq: a 32-bit and an 8-bit instance share
// one stimulus stream and are checked each cycle against a timeline model.
module tb_fibonacci_seq;
  import fib_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic [15:0] n     = '0;
  logic [31:0] seed0 = '0;
  logic [31:0] seed1 = '0;

  logic        fin32, busy32, ovf32;
  logic [31:0] result32;
  logic        fin8, busy8, ovf8;
  logic [7:0]  result8;
`ifdef FIB_STREAM_EN
  logic        tv32, tv8;
  logic [31:0] term32;
  logic [7:0]  term8;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Scoreboard of the transaction in flight (edge numbers are values of cyc).
  bit              txActive = 1'b0;
  int              tAcc     = 0;
  int              txN      = 0;
  int              finFall  = -1;
  longint unsigned txS0, txS1, txRes32, txRes8;
  bit              txOvf32, txOvf8;
  longint unsigned comRes32 = 0, comRes8 = 0;
  bit              comOvf32 = 0, comOvf8 = 0;
  int              busyCycles = 0;
  longint unsigned streamQ[$];

  fibonacci_seq #(.Width(32), .NWidth(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .req(req), .n(n), .seed0(seed0), .seed1(seed1),
    .fin(fin32), .busy(busy32), .result(result32), .ovf(ovf32)
`ifdef FIB_STREAM_EN
    , .term_vld(tv32), .term(term32)
`endif
  );

  fibonacci_seq #(.Width(8), .NWidth(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .n(n[7:0]), .seed0(seed0[7:0]),
    .seed1(seed1[7:0]), .fin(fin8), .busy(busy8), .result(result8), .ovf(ovf8)
`ifdef FIB_STREAM_EN
    , .term_vld(tv8), .term(term8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // x(k) mod 2^w, and whether any true x(j), j<=k, reached 2^w.
  function automatic void seqModel(input longint unsigned s0, input longint unsigned s1,
                                   input int k, input int w,
                                   output longint unsigned res, output bit ov);
    longint unsigned cap, mask, m0, m1, t0, t1, tmp;
    cap  = 64'd1 << w;
    mask = cap - 1;
    m0 = s0 & mask;  m1 = s1 & mask;
    t0 = m0;         t1 = m1;
    ov = 1'b0;
    if (k == 0) begin
      res = m0;
      return;
    end
    for (int j = 2; j <= k; j++) begin
      tmp = (m0 + m1) & mask;
      m0 = m1;  m1 = tmp;
      tmp = t0 + t1;
      if (tmp > cap) tmp = cap;
      t0 = t1;  t1 = tmp;
      if (t1 >= cap) ov = 1'b1;
    end
    res = m1;
  endfunction

  always @(negedge clk) begin : compare
    bit              eBusy, eFin, captured, o;
    longint unsigned eR32, eR8;
    bit              eO32, eO8;
    if (!rst_n) begin
      eBusy = 0; eFin = 0; eR32 = 0; eR8 = 0; eO32 = 0; eO8 = 0;
    end else begin
      eBusy    = txActive && cyc >= tAcc && cyc < tAcc + txN;
      eFin     = txActive && cyc >= tAcc + txN + 2 && (finFall < 0 || cyc < finFall);
      captured = txActive && cyc >= tAcc + txN + 1;
      eR32 = captured ? txRes32 : comRes32;
      eO32 = captured ? txOvf32 : comOvf32;
      eR8  = captured ? txRes8  : comRes8;
      eO8  = captured ? txOvf8  : comOvf8;
    end
    check("busy32", busy32, eBusy);
    check("fin32", fin32, eFin);
    check("result32", result32, eR32);
    check("ovf32", ovf32, eO32);
    check("busy8", busy8, eBusy);
    check("fin8", fin8, eFin);
    check("result8", result8, eR8);
    check("ovf8", ovf8, eO8);
`ifdef FIB_STREAM_EN
    begin
      bit              eVld;
      longint unsigned t32, t8;
      eVld = rst_n && txActive && cyc >= tAcc + 1 && cyc <= tAcc + txN + 1;
      t32 = 0; t8 = 0;
      if (eVld) begin
        seqModel(txS0, txS1, cyc - tAcc - 1, 32, t32, o);
        seqModel(txS0, txS1, cyc - tAcc - 1, 8, t8, o);
      end
      check("term_vld32", tv32, eVld);
      check("term32", term32, t32);
      check("term_vld8", tv8, eVld);
      check("term8", term8, t8);
      if (tv32) streamQ.push_back(term32);
    end
`endif
    if (busy32) busyCycles++;
  end

  task automatic advance(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " fin32"}, fin32, 0);
    check({tag, " busy32"}, busy32, 0);
    check({tag, " result32"}, result32, 0);
    check({tag, " ovf32"}, ovf32, 0);
    check({tag, " result8"}, result8, 0);
    check({tag, " ovf8"}, ovf8, 0);
  endtask

  task automatic doReset();
    req      = 1'b0;
    rst_n    = 1'b0;
    txActive = 1'b0;
    comRes32 = 0; comRes8 = 0; comOvf32 = 0; comOvf8 = 0;
    #1;
    checkAllZero("async reset");
    advance(2);
    rst_n = 1'b1;
  endtask

  // Called just after an active edge; returns just after the accept edge.
  task automatic startTxn(input int nn, input longint unsigned s0, input longint unsigned s1);
    n = nn[15:0]; seed0 = s0[31:0]; seed1 = s1[31:0]; req = 1'b1;
    txS0 = s0[31:0]; txS1 = s1[31:0]; txN = nn;
    tAcc = cyc + 1; finFall = -1;
    seqModel(txS0, txS1, nn, 32, txRes32, txOvf32);
    seqModel(txS0, txS1, nn, 8, txRes8, txOvf8);
    txActive = 1'b1;
    advance(1);
    // Inputs are only sampled at acceptance; scramble them afterwards.
    n = 16'($urandom); seed0 = $urandom; seed1 = $urandom;
  endtask

  task automatic finishTxn(input int hold);
    int budget;
    bit seen;
    budget = txN + 8;
    seen = 1'b0;
    while (!seen && budget > 0) begin
      if (fin32) seen = 1'b1;
      else begin
        advance(1);
        budget--;
      end
    end
    check("fin rises", seen, 1);
    if (!seen) begin
      doReset();
      return;
    end
    check("fin latency", longint'(cyc), longint'(tAcc + txN + 2));
    advance(hold);
    req = 1'b0;
    finFall = cyc + 1;
    advance(1);
    comRes32 = txRes32; comRes8 = txRes8; comOvf32 = txOvf32; comOvf8 = txOvf8;
    txActive = 1'b0;
  endtask

  // Request stays high on k edges starting at the accept edge, then drops.
  task automatic abortTxn(input int k);
    advance(k - 1);
    req = 1'b0;
    advance(1);
    txActive = 1'b0;
    check("busy after abort", busy32, 0);
  endtask

  initial begin : stimulus
    longint unsigned r;
    bit              o;
    int              nn, k;
    longint unsigned s0, s1;

    seqModel(FIB_SEED0, FIB_SEED1, 10, 32, r, o);
    check("model fib10", r, 55);
    seqModel(LUCAS_SEED0, LUCAS_SEED1, 5, 32, r, o);
    check("model lucas5", r, 11);
    seqModel(0, 1, 14, 8, r, o);
    check("model fib14 w8", {r, 1'b0} | o, {64'd121, 1'b1});

    advance(2);
    checkAllZero("reset");
    rst_n = 1'b1;
    advance(1);

    // Fibonacci n=10.
    busyCycles = 0;
    startTxn(10, FIB_SEED0, FIB_SEED1);
    finishTxn(1);
    check("fib10 result", result32, 55);
    check("fib10 ovf", ovf32, 0);
    check("fib10 busy cycles", busyCycles, 10);

    // n=0 and n=1 return the seeds.
    startTxn(0, 0, 1);  finishTxn(0);  check("n0 result", result32, 0);
    startTxn(1, 0, 1);  finishTxn(2);  check("n1 result", result32, 1);
    startTxn(0, 7, 9);  finishTxn(0);  check("n0 seed0", result32, 7);
    startTxn(1, 7, 9);  finishTxn(0);  check("n1 seed1", result32, 9);

    startTxn(5, LUCAS_SEED0, LUCAS_SEED1);
    finishTxn(0);
    check("lucas5 result", result32, 11);

    // Narrow width: last term that fits, then first that overflows.
    startTxn(13, 0, 1);  finishTxn(0);
    check("w8 n13 result", result8, 233);  check("w8 n13 ovf", ovf8, 0);
    startTxn(14, 0, 1);  finishTxn(1);
    check("w8 n14 result", result8, 121);  check("w8 n14 ovf", ovf8, 1);
    check("w32 n14 result", result32, 377);

    startTxn(100, 0, 0);  finishTxn(0);
    check("zero seeds result", result32, 0);  check("zero seeds ovf", ovf32, 0);
    startTxn(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  finishTxn(0);
    check("max seeds result", result32, 64'hFFFF_FFFE);  check("max seeds ovf", ovf32, 1);
    startTxn(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  finishTxn(0);
    check("max seeds n1 ovf", ovf32, 0);

    // Abort keeps the prior result; reset mid-CALC clears everything.
    startTxn(10, 0, 1);  finishTxn(0);
    startTxn(20, 0, 1);  abortTxn(5);
    advance(3);
    check("abort result", result32, 55);
    check("abort fin", fin32, 0);
    startTxn(30, 3, 4);
    advance(4);
    doReset();
    advance(1);

`ifdef FIB_STREAM_EN
    streamQ.delete();
    startTxn(6, 0, 1);
    finishTxn(0);
    check("stream length", streamQ.size(), 7);
    begin
      longint unsigned lit[7] = '{0, 1, 1, 2, 3, 5, 8};
      for (int j = 0; j < 7 && j < streamQ.size(); j++) check("stream term", streamQ[j], lit[j]);
    end
`endif

    for (int t = 0; t < 60; t++) begin
      nn = $urandom_range(0, 40);
      case ($urandom_range(0, 3))
        0: begin s0 = $urandom_range(0, 20); s1 = $urandom_range(0, 20); end
        1: begin s0 = FIB_SEED0; s1 = FIB_SEED1; end
        2: begin s0 = 32'hFFFF_FFFF - $urandom_range(0, 99); s1 = $urandom; end
        default: begin s0 = $urandom; s1 = $urandom; end
      endcase
      startTxn(nn, s0, s1);
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, nn + 1);
        abortTxn(k);
      end else begin
        finishTxn($urandom_range(0, 3));
      end
      advance($urandom_range(0, 2));
    end

    // Largest index for the 8-bit-index instance.
    startTxn(255, 0, 1);
    finishTxn(0);
    check("n255 w8 ovf", ovf8, 1);

    advance(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
